// File: rtl/threshold_alarm_pkg.sv
// Shared types and constants for the threshold alarm block.
package threshold_alarm_pkg;

    localparam int DATA_W    = 4;
    localparam int RUN_W     = 4;
    localparam int COUNT_MIN = 1;
    localparam int COUNT_MAX = 15;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        ARMING   = 2'd1,
        ALARM    = 2'd2,
        CLEARING = 2'd3
    } state_t;

    function automatic logic count_in_range(input int c);
        return (c >= COUNT_MIN) && (c <= COUNT_MAX);
    endfunction

endpackage

// File: rtl/comparator_four_bit.sv
// Combinational 4-bit unsigned magnitude comparator (A versus B).
module comparator_four_bit
    import threshold_alarm_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              Greater_than,
    output logic              Less_than,
    output logic              Equal
);

    assign Greater_than = (A > B);
    assign Less_than    = (A < B);
    assign Equal        = (A == B);

endmodule

// File: rtl/threshold_alarm.sv
// Streaming threshold monitor: registers samples, compares them against a
// programmable threshold and debounces the result into a hysteretic alarm.
module threshold_alarm
    import threshold_alarm_pkg::*;
#(
    parameter int TRIP_COUNT  = 3,
    parameter int CLEAR_COUNT = 2,
    parameter int TOT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              thr_load,
    input  logic [DATA_W-1:0] thr_in,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              alarm,
    output logic              trip_pulse,
    output logic              clear_pulse,
    output logic              last_gt,
    output logic              last_lt,
    output logic              last_eq,
    output logic [TOT_W-1:0]  gt_total,
    output logic [1:0]        dbg_state
);

    // Handshake: a sample transfers on a rising edge where s_valid && s_ready.
    // s_ready drops during a threshold load so upstream holds the sample.

    generate
        if (!count_in_range(TRIP_COUNT)) begin : g_bad_trip
            $error("threshold_alarm: TRIP_COUNT must be within 1..15");
        end
        if (!count_in_range(CLEAR_COUNT)) begin : g_bad_clear
            $error("threshold_alarm: CLEAR_COUNT must be within 1..15");
        end
        if (TOT_W < 1) begin : g_bad_tot
            $error("threshold_alarm: TOT_W must be at least 1");
        end
    endgenerate

    localparam logic [RUN_W-1:0] TRIP_RUN  = RUN_W'(TRIP_COUNT);
    localparam logic [RUN_W-1:0] CLEAR_RUN = RUN_W'(CLEAR_COUNT);
    localparam logic [TOT_W-1:0] TOT_MAX   = '1;

    logic [DATA_W-1:0] r_thr_q;
    logic [DATA_W-1:0] r_samp_q;
    logic              r_samp_v;
    state_t            r_state;
    logic [RUN_W-1:0]  r_run;
    logic              r_alarm;
    logic              r_trip;
    logic              r_clear;
    logic              r_last_gt;
    logic              r_last_lt;
    logic              r_last_eq;
    logic [TOT_W-1:0]  r_gt_total;

    logic              w_accept;
    logic              w_gt;
    logic              w_lt;
    logic              w_eq;
    logic [RUN_W-1:0]  w_run_inc;

    assign s_ready   = !thr_load && !rst;
    assign w_accept  = s_valid && s_ready;
    assign w_run_inc = r_run + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp_q <= '0;
            r_samp_v <= 1'b0;
            r_thr_q  <= '0;
        end else begin
            r_samp_v <= w_accept;
            if (w_accept) begin
                r_samp_q <= s_data;
            end
            if (thr_load) begin
                r_thr_q <= thr_in;
            end
        end
    end

    comparator_four_bit u_cmp (
        .A            (r_samp_q),
        .B            (r_thr_q),
        .Greater_than (w_gt),
        .Less_than    (w_lt),
        .Equal        (w_eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= NORMAL;
            r_run      <= '0;
            r_alarm    <= 1'b0;
            r_trip     <= 1'b0;
            r_clear    <= 1'b0;
            r_last_gt  <= 1'b0;
            r_last_lt  <= 1'b0;
            r_last_eq  <= 1'b0;
            r_gt_total <= '0;
        end else begin
            r_trip  <= 1'b0;
            r_clear <= 1'b0;
            if (r_samp_v) begin
                r_last_gt <= w_gt;
                r_last_lt <= w_lt;
                r_last_eq <= w_eq;
            end
            // A load wins over the in-flight sample: its run/total effect is dropped.
            if (thr_load) begin
                r_run      <= '0;
                r_gt_total <= '0;
                case (r_state)
                    ARMING:   r_state <= NORMAL;
                    CLEARING: r_state <= ALARM;
                    default:  r_state <= r_state;
                endcase
            end else if (r_samp_v) begin
                if (w_gt && (r_gt_total != TOT_MAX)) begin
                    r_gt_total <= r_gt_total + 1'b1;
                end
                case (r_state)
                    NORMAL: begin
                        if (w_gt) begin
                            if (TRIP_COUNT == 1) begin
                                r_state <= ALARM;
                                r_alarm <= 1'b1;
                                r_trip  <= 1'b1;
                                r_run   <= '0;
                            end else begin
                                r_state <= ARMING;
                                r_run   <= 4'd1;
                            end
                        end
                    end
                    ARMING: begin
                        if (w_gt) begin
                            if (w_run_inc == TRIP_RUN) begin
                                r_state <= ALARM;
                                r_alarm <= 1'b1;
                                r_trip  <= 1'b1;
                                r_run   <= '0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end else begin
                            r_state <= NORMAL;
                            r_run   <= '0;
                        end
                    end
                    ALARM: begin
                        if (!w_gt) begin
                            if (CLEAR_COUNT == 1) begin
                                r_state <= NORMAL;
                                r_alarm <= 1'b0;
                                r_clear <= 1'b1;
                                r_run   <= '0;
                            end else begin
                                r_state <= CLEARING;
                                r_run   <= 4'd1;
                            end
                        end
                    end
                    CLEARING: begin
                        if (!w_gt) begin
                            if (w_run_inc == CLEAR_RUN) begin
                                r_state <= NORMAL;
                                r_alarm <= 1'b0;
                                r_clear <= 1'b1;
                                r_run   <= '0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end else begin
                            r_state <= ALARM;
                            r_run   <= '0;
                        end
                    end
                    default: begin
                        r_state <= NORMAL;
                        r_run   <= '0;
                    end
                endcase
            end
        end
    end

    assign alarm       = r_alarm;
    assign trip_pulse  = r_trip;
    assign clear_pulse = r_clear;
    assign last_gt     = r_last_gt;
    assign last_lt     = r_last_lt;
    assign last_eq     = r_last_eq;
    assign gt_total    = r_gt_total;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_threshold_alarm.sv
// Directed bench for threshold_alarm with a run-length alarm model and per-cycle compare.
module tb_threshold_alarm;
    import threshold_alarm_pkg::*;

    localparam int TRIP    = 3;
    localparam int CLEAR   = 2;
    localparam int TOT_W   = 8;
    localparam int TOT_MAX = (1 << TOT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             thr_load;
    logic [3:0]       thr_in;
    logic             s_valid;
    logic [3:0]       s_data;
    logic             s_ready;
    logic             alarm;
    logic             trip_pulse;
    logic             clear_pulse;
    logic             last_gt;
    logic             last_lt;
    logic             last_eq;
    logic [TOT_W-1:0] gt_total;
    logic [1:0]       dbg_state;

    int n_chk  = 0;
    int n_fail = 0;
    int trip_seen = 0;

    threshold_alarm #(.TRIP_COUNT(TRIP), .CLEAR_COUNT(CLEAR), .TOT_W(TOT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .thr_load    (thr_load),
        .thr_in      (thr_in),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .alarm       (alarm),
        .trip_pulse  (trip_pulse),
        .clear_pulse (clear_pulse),
        .last_gt     (last_gt),
        .last_lt     (last_lt),
        .last_eq     (last_eq),
        .gt_total    (gt_total),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: alarm rises after TRIP consecutive greater samples, falls after
    // CLEAR consecutive not-greater samples; a load restarts both runs.
    int m_thr, m_pv, m_pd, m_alarm, m_g, m_ng, m_total;
    int m_gt, m_lt, m_eq, m_trip, m_clear;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_thr = 0; m_pv = 0; m_pd = 0; m_alarm = 0; m_g = 0; m_ng = 0;
            m_total = 0; m_gt = 0; m_lt = 0; m_eq = 0; m_trip = 0; m_clear = 0;
        end else begin
            m_trip  = 0;
            m_clear = 0;
            if (m_pv != 0) begin
                m_gt = (m_pd > m_thr) ? 1 : 0;
                m_lt = (m_pd < m_thr) ? 1 : 0;
                m_eq = (m_pd == m_thr) ? 1 : 0;
                if (!thr_load) begin
                    if (m_gt != 0) begin
                        if (m_total < TOT_MAX) m_total++;
                        m_g++;
                        m_ng = 0;
                    end else begin
                        m_ng++;
                        m_g = 0;
                    end
                    if (m_alarm == 0 && m_g >= TRIP) begin
                        m_alarm = 1; m_trip = 1; m_g = 0;
                    end else if (m_alarm != 0 && m_ng >= CLEAR) begin
                        m_alarm = 0; m_clear = 1; m_ng = 0;
                    end
                end
            end
            if (thr_load) begin
                m_thr = int'(thr_in); m_g = 0; m_ng = 0; m_total = 0;
            end
            m_pv = (s_valid && !thr_load) ? 1 : 0;
            m_pd = int'(s_data);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("alarm", int'(alarm), m_alarm);
            chk("trip_pulse", int'(trip_pulse), m_trip);
            chk("clear_pulse", int'(clear_pulse), m_clear);
            chk("last_gt", int'(last_gt), m_gt);
            chk("last_lt", int'(last_lt), m_lt);
            chk("last_eq", int'(last_eq), m_eq);
            chk("gt_total", int'(gt_total), m_total);
            chk("s_ready", int'(s_ready), thr_load ? 0 : 1);
            if (trip_pulse) trip_seen++;
        end
    end

    task automatic step(input logic v, input logic [3:0] d, input logic ld, input logic [3:0] t);
        @(negedge clk);
        #1;
        s_valid  = v;
        s_data   = d;
        thr_load = ld;
        thr_in   = t;
    endtask

    task automatic send(input logic [3:0] d);
        step(1'b1, d, 1'b0, 4'd0);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic load(input logic [3:0] t);
        step(1'b0, 4'd0, 1'b1, t);
    endtask

    initial begin
        rst = 1'b1; thr_load = 1'b0; thr_in = '0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_gt_total", int'(gt_total), 0);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_state", int'(dbg_state), int'(NORMAL));
        rst = 1'b0;

        // Trip on three consecutive greater samples.
        load(4'd9);
        send(4'd10); send(4'd11); send(4'd12);
        idle(); idle();
        chk("trip_pulse_lit", int'(trip_pulse), 1);
        chk("trip_alarm_lit", int'(alarm), 1);
        chk("trip_total_lit", int'(gt_total), 3);
        idle();
        chk("trip_pulse_once", int'(trip_pulse), 0);

        // Hysteresis: a single not-greater sample does not clear.
        send(4'd3); send(4'd12); send(4'd3);
        chk("hyst_alarm_a", int'(alarm), 1);
        send(4'd3);
        idle();
        chk("hyst_alarm_b", int'(alarm), 1);
        idle();
        chk("hyst_clear_lit", int'(clear_pulse), 1);
        chk("hyst_alarm_off", int'(alarm), 0);

        // Equal breaks a greater run.
        send(4'd10); send(4'd9); send(4'd10); send(4'd10);
        chk("eq_last_eq", int'(last_eq), 1);
        send(4'd10);
        idle();
        chk("eq_no_trip", int'(trip_pulse), 0);
        chk("eq_alarm_low", int'(alarm), 0);
        idle();
        chk("eq_trip", int'(trip_pulse), 1);
        send(4'd0); send(4'd0); idle(); idle();
        chk("eq_clear", int'(clear_pulse), 1);

        // Load collides with a valid sample: sample stalls, then compares to 15.
        step(1'b1, 4'd14, 1'b1, 4'd15);
        #1;
        chk("coll_s_ready", int'(s_ready), 0);
        step(1'b1, 4'd14, 1'b0, 4'd0);
        idle(); idle();
        chk("coll_last_lt", int'(last_lt), 1);
        chk("coll_total", int'(gt_total), 0);

        // Load during ARMING discards the run and the in-flight sample.
        load(4'd5);
        send(4'd6); send(4'd6);
        load(4'd5);
        send(4'd6); send(4'd6); send(4'd6);
        chk("arm_load_alarm", int'(alarm), 0);
        idle(); idle();
        chk("arm_load_trip", int'(trip_pulse), 1);
        chk("arm_load_total", int'(gt_total), 3);
        send(4'd0); send(4'd0); idle(); idle();
        chk("arm_clear", int'(alarm), 0);

        // Saturation with a zero threshold.
        trip_seen = 0;
        load(4'd0);
        repeat (260) send(4'd15);
        idle(); idle();
        chk("sat_total", int'(gt_total), 255);
        chk("sat_alarm", int'(alarm), 1);
        chk("sat_trip_count", trip_seen, 1);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_alarm", int'(alarm), 0);
        chk("arst_total", int'(gt_total), 0);
        chk("arst_last_gt", int'(last_gt), 0);
        chk("arst_s_ready", int'(s_ready), 0);
        chk("arst_state", int'(dbg_state), int'(NORMAL));
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
